// File: rtl/qtree_radix_pipe.sv
// qtree_radix_pipe: RADIX-ary search-tree lookup pipeline with a leaf exact-match stage,
// valid/ready backpressure, unified config write port and saturating statistics.
module qtree_radix_pipe #(
   parameter int STAGES = 3,
   parameter int RADIX = 4,
   parameter int DATA_WIDTH = 16,
   parameter int D_CNT = 4,
   localparam int LOG2R = $clog2(RADIX),
   localparam int LOG2D = $clog2(D_CNT),
   localparam int LEAF_AW = STAGES * LOG2R,
   localparam int OUT_ADDR_WIDTH = LEAF_AW + LOG2D,
   localparam int SEL_W = $clog2(STAGES + 1),
   localparam int IDX_W = (LOG2R > LOG2D) ? LOG2R : LOG2D
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      lookup_valid_i,
   output logic                      lookup_ready_o,
   input  logic [DATA_WIDTH-1:0]     lookup_data_i,
   output logic                      lookup_valid_o,
   input  logic                      lookup_ready_i,
   output logic                      lookup_match_o,
   output logic [OUT_ADDR_WIDTH-1:0] lookup_addr_o,
   output logic [DATA_WIDTH-1:0]     lookup_data_o,
   input  logic                      cfg_valid_i,
   input  logic [SEL_W-1:0]          cfg_sel_i,
   input  logic [LEAF_AW-1:0]        cfg_addr_i,
   input  logic [IDX_W-1:0]          cfg_idx_i,
   input  logic [DATA_WIDTH-1:0]     cfg_data_i,
   input  logic                      cfg_en_i,
   output logic [31:0]               stat_lookups_o,
   output logic [31:0]               stat_matches_o
);
   localparam int NL = RADIX ** STAGES;
   logic                      en;
   logic [STAGES:0]           s_vld;
   logic [LEAF_AW-1:0]        s_addr [STAGES+1];
   logic [DATA_WIDTH-1:0]     s_dat [STAGES+1];
   logic                      out_vld_q, out_match_q;
   logic [OUT_ADDR_WIDTH-1:0] out_addr_q;
   logic [DATA_WIDTH-1:0]     out_data_q;
   logic [31:0]               stat_lookups_q, stat_matches_q;
   assign en = !out_vld_q || lookup_ready_i;
   assign lookup_ready_o = en;
   assign s_vld[0] = lookup_valid_i;
   assign s_addr[0] = '0;
   assign s_dat[0] = lookup_data_i;
   genvar g, n, k;
   for (g = 0; g < STAGES; g++) begin : g_stage
      localparam int NN = RADIX ** g;
      localparam int NW = (g == 0) ? 1 : g * LOG2R;
      logic [RADIX-2:0][DATA_WIDTH-1:0] keys [NN];
      logic [RADIX-2:0][DATA_WIDTH-1:0] row;
      logic [RADIX-2:0]                 le;
      logic [LOG2R-1:0]                 idx;
      logic                             p_vld_q;
      logic [LEAF_AW-1:0]               p_addr_q;
      logic [DATA_WIDTH-1:0]            p_dat_q;
      for (n = 0; n < NN; n++) begin : g_node
         for (k = 0; k < RADIX - 1; k++) begin : g_key
            logic [DATA_WIDTH-1:0] key_q;
            always_ff @(posedge clk_i or negedge rst_i)
               if (!rst_i) key_q <= '1;
               else if (cfg_valid_i && cfg_sel_i == SEL_W'(g) && cfg_addr_i == LEAF_AW'(n) &&
                        cfg_idx_i == IDX_W'(k)) key_q <= cfg_data_i;
            assign keys[n][k] = key_q;
         end
      end
      if (g == 0) begin : g_root
         assign row = keys[0];
      end else begin : g_inner
         assign row = keys[s_addr[g][NW-1:0]];
      end
      // branch index counts keys not above the search value, so key order does not matter
      for (k = 0; k < RADIX - 1; k++) begin : g_cmp
         assign le[k] = row[k] <= s_dat[g];
      end
      assign idx = LOG2R'($countones(le));
      always_ff @(posedge clk_i or negedge rst_i)
         if (!rst_i) begin
            p_vld_q <= 1'b0;
            p_addr_q <= '0;
            p_dat_q <= '0;
         end else if (en) begin
            p_vld_q <= s_vld[g];
            p_addr_q <= (s_addr[g] << LOG2R) | LEAF_AW'(idx);
            p_dat_q <= s_dat[g];
         end
      assign s_vld[g+1] = p_vld_q;
      assign s_addr[g+1] = p_addr_q;
      assign s_dat[g+1] = p_dat_q;
   end
   logic [D_CNT-1:0][DATA_WIDTH:0] ents [NL];
   logic [D_CNT-1:0][DATA_WIDTH:0] lrow;
   logic [D_CNT-1:0]               hit;
   logic [LOG2D-1:0]               eidx;
   for (n = 0; n < NL; n++) begin : g_leaf
      for (k = 0; k < D_CNT; k++) begin : g_ent
         logic [DATA_WIDTH:0] ent_q;
         always_ff @(posedge clk_i or negedge rst_i)
            if (!rst_i) ent_q <= '0;
            else if (cfg_valid_i && cfg_sel_i == SEL_W'(STAGES) && cfg_addr_i == LEAF_AW'(n) &&
                     cfg_idx_i == IDX_W'(k)) ent_q <= {cfg_en_i, cfg_data_i};
         assign ents[n][k] = ent_q;
      end
   end
   assign lrow = ents[s_addr[STAGES]];
   for (k = 0; k < D_CNT; k++) begin : g_hit
      assign hit[k] = lrow[k] == {1'b1, s_dat[STAGES]};
   end
   always_comb begin
      eidx = '0;
      for (int e = D_CNT - 1; e >= 0; e--) if (hit[e]) eidx = LOG2D'(e);
   end
   always_ff @(posedge clk_i or negedge rst_i)
      if (!rst_i) begin
         out_vld_q <= 1'b0;
         out_match_q <= 1'b0;
         out_addr_q <= '0;
         out_data_q <= '0;
      end else if (en) begin
         out_vld_q <= s_vld[STAGES];
         out_match_q <= s_vld[STAGES] && |hit;
         out_addr_q <= {s_addr[STAGES], eidx};
         out_data_q <= s_dat[STAGES];
      end
   always_ff @(posedge clk_i or negedge rst_i)
      if (!rst_i) begin
         stat_lookups_q <= '0;
         stat_matches_q <= '0;
      end else begin
         if (lookup_valid_i && en && stat_lookups_q != '1) stat_lookups_q <= stat_lookups_q + 32'd1;
         if (out_vld_q && lookup_ready_i && out_match_q && stat_matches_q != '1)
            stat_matches_q <= stat_matches_q + 32'd1;
      end
   assign lookup_valid_o = out_vld_q;
   assign lookup_match_o = out_match_q;
   assign lookup_addr_o = out_addr_q;
   assign lookup_data_o = out_data_q;
   assign stat_lookups_o = stat_lookups_q;
   assign stat_matches_o = stat_matches_q;
endmodule

// File: tb/tb_qtree_radix_pipe.sv
// tb_qtree_radix_pipe: directed checks of qtree_radix_pipe with STAGES=2, RADIX=4, D_CNT=4.
module tb_qtree_radix_pipe;
   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        lookup_valid_i, lookup_ready_o, lookup_valid_o, lookup_ready_i, lookup_match_o;
   logic [15:0] lookup_data_i, lookup_data_o;
   logic [5:0]  lookup_addr_o;
   logic        cfg_valid_i, cfg_en_i;
   logic [1:0]  cfg_sel_i, cfg_idx_i;
   logic [3:0]  cfg_addr_i;
   logic [15:0] cfg_data_i;
   logic [31:0] stat_lookups_o, stat_matches_o;
   int          checks = 0;
   int          errors = 0;
   int          sent, got, cyc;
   logic [15:0] bv [5] = '{16'h2500, 16'h2501, 16'h0005, 16'h1500, 16'h2900};
   logic        bm [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
   logic [5:0]  ba [5] = '{6'd41, 6'd40, 6'd0, 6'd18, 6'd44};

   qtree_radix_pipe #(.STAGES(2), .RADIX(4), .DATA_WIDTH(16), .D_CNT(4)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .lookup_valid_i(lookup_valid_i), .lookup_ready_o(lookup_ready_o), .lookup_data_i(lookup_data_i),
      .lookup_valid_o(lookup_valid_o), .lookup_ready_i(lookup_ready_i), .lookup_match_o(lookup_match_o),
      .lookup_addr_o(lookup_addr_o), .lookup_data_o(lookup_data_o),
      .cfg_valid_i(cfg_valid_i), .cfg_sel_i(cfg_sel_i), .cfg_addr_i(cfg_addr_i), .cfg_idx_i(cfg_idx_i),
      .cfg_data_i(cfg_data_i), .cfg_en_i(cfg_en_i),
      .stat_lookups_o(stat_lookups_o), .stat_matches_o(stat_matches_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cfg(input logic [1:0] s, input logic [3:0] a, input logic [1:0] i,
                      input logic [15:0] d, input logic e);
      @(negedge clk_i);
      cfg_valid_i = 1'b1; cfg_sel_i = s; cfg_addr_i = a; cfg_idx_i = i; cfg_data_i = d; cfg_en_i = e;
      @(negedge clk_i);
      cfg_valid_i = 1'b0;
   endtask

   // one request, result expected two negedges after the accepting one
   task automatic lookup(input logic [15:0] d, input logic m, input logic [5:0] a, input string tag);
      int n;
      @(negedge clk_i);
      lookup_valid_i = 1'b1; lookup_data_i = d; lookup_ready_i = 1'b1;
      @(negedge clk_i);
      lookup_valid_i = 1'b0;
      n = 0;
      while (!lookup_valid_o && n < 10) begin
         @(negedge clk_i);
         n++;
      end
      chk({tag, "_lat"}, n, 2);
      chk({tag, "_match"}, lookup_match_o, m);
      chk({tag, "_addr"}, lookup_addr_o, a);
      chk({tag, "_data"}, lookup_data_o, d);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      lookup_valid_i = 1'b0; lookup_data_i = '0; lookup_ready_i = 1'b1;
      cfg_valid_i = 1'b0; cfg_sel_i = '0; cfg_addr_i = '0; cfg_idx_i = '0; cfg_data_i = '0; cfg_en_i = 1'b0;
      repeat (2) @(negedge clk_i);
      chk("rst0_valid", lookup_valid_o, 0);
      chk("rst0_ready", lookup_ready_o, 1);
      chk("rst0_stat", stat_lookups_o, 0);
      rst_i = 1'b1;
      @(negedge clk_i);
      lookup_valid_i = 1'b1; lookup_data_i = 16'hFFFF;
      repeat (3) @(negedge clk_i);
      chk("pre_valid", lookup_valid_o, 1);
      chk("pre_addr", lookup_addr_o, 6'h3C);
      chk("pre_data", lookup_data_o, 16'hFFFF);
      chk("pre_stat", stat_lookups_o, 3);
      rst_i = 1'b0;
      lookup_valid_i = 1'b0;
      #1;
      chk("rst_valid", lookup_valid_o, 0);
      chk("rst_match", lookup_match_o, 0);
      chk("rst_addr", lookup_addr_o, 0);
      chk("rst_data", lookup_data_o, 0);
      chk("rst_ready", lookup_ready_o, 1);
      chk("rst_stat", stat_lookups_o, 0);
      repeat (2) @(negedge clk_i);
      rst_i = 1'b1;
      repeat (3) @(negedge clk_i);
      chk("drop_valid", lookup_valid_o, 0);
      lookup(16'h0000, 1'b0, 6'd0, "zero");
      cfg(0, 0, 0, 16'h1000, 0);
      cfg(0, 0, 1, 16'h2000, 0);
      cfg(0, 0, 2, 16'h3000, 0);
      cfg(1, 2, 0, 16'h2100, 0);
      cfg(1, 2, 1, 16'h2400, 0);
      cfg(1, 2, 2, 16'h2800, 0);
      cfg(2, 10, 1, 16'h2500, 1);
      lookup(16'h2500, 1'b1, 6'd41, "hit");
      lookup(16'h2501, 1'b0, 6'd40, "miss");
      cfg(2, 10, 3, 16'h2500, 1);
      lookup(16'h2500, 1'b1, 6'd41, "dup");
      cfg(2, 10, 1, 16'h2500, 0);
      lookup(16'h2500, 1'b1, 6'd43, "dup_e3");
      cfg(2, 10, 1, 16'h2500, 1);
      cfg(1, 1, 0, 16'h2100, 0);
      cfg(1, 1, 1, 16'h2400, 0);
      cfg(1, 1, 2, 16'h2800, 0);
      cfg(2, 4, 2, 16'h1500, 1);
      // five back-to-back requests, downstream stalled for the first four cycles
      sent = 0; got = 0; cyc = 0;
      @(negedge clk_i);
      while (got < 5 && cyc < 40) begin
         lookup_ready_i = (cyc >= 4);
         lookup_valid_i = (sent < 5);
         lookup_data_i = (sent < 5) ? bv[sent] : 16'h0;
         #1;
         if (cyc == 3) begin
            chk("bp_ready", lookup_ready_o, 0);
            chk("bp_hold_valid", lookup_valid_o, 1);
            chk("bp_hold_data", lookup_data_o, 16'h2500);
         end
         if (cyc == 4) chk("bp_stable", lookup_addr_o, 6'd41);
         if (lookup_valid_o && lookup_ready_i) begin
            chk("bp_data", lookup_data_o, bv[got]);
            chk("bp_match", lookup_match_o, bm[got]);
            chk("bp_addr", lookup_addr_o, ba[got]);
            got++;
         end
         if (lookup_valid_i && lookup_ready_o) sent++;
         @(negedge clk_i);
         cyc++;
      end
      lookup_valid_i = 1'b0; lookup_ready_i = 1'b1;
      chk("bp_count", got, 5);
      repeat (2) @(negedge clk_i);
      chk("bp_nodup", lookup_valid_o, 0);
      // key rewrite in the accepting cycle must not affect that request
      @(negedge clk_i);
      lookup_valid_i = 1'b1; lookup_data_i = 16'h2500;
      cfg_valid_i = 1'b1; cfg_sel_i = 0; cfg_addr_i = 0; cfg_idx_i = 0; cfg_data_i = 16'h3000; cfg_en_i = 1'b0;
      @(negedge clk_i);
      cfg_valid_i = 1'b0;
      @(negedge clk_i);
      lookup_valid_i = 1'b0;
      @(negedge clk_i);
      chk("col_old_valid", lookup_valid_o, 1);
      chk("col_old_match", lookup_match_o, 1);
      chk("col_old_addr", lookup_addr_o, 6'd41);
      @(negedge clk_i);
      chk("col_new_valid", lookup_valid_o, 1);
      chk("col_new_match", lookup_match_o, 0);
      chk("col_new_addr", lookup_addr_o, 6'd24);
      cfg(1, 5, 0, 16'h2600, 0);
      cfg(3, 6, 0, 16'h2500, 1);
      lookup(16'h2500, 1'b0, 6'd24, "ign");
      @(negedge clk_i);
      chk("stat_lookups", stat_lookups_o, 13);
      chk("stat_matches", stat_matches_o, 6);
      cfg(2, 6, 0, 16'h2500, 1);
      @(negedge clk_i);
      force dut.stat_matches_q = 32'hFFFF_FFFE;
      #1;
      release dut.stat_matches_q;
      lookup(16'h2500, 1'b1, 6'd24, "sat1");
      lookup(16'h2500, 1'b1, 6'd24, "sat2");
      lookup(16'h2500, 1'b1, 6'd24, "sat3");
      @(negedge clk_i);
      chk("stat_sat", stat_matches_o, 32'hFFFF_FFFF);
      chk("stat_lookups_end", stat_lookups_o, 16);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
